// File: rtl/program_loader.sv
// Serial-link program loader: receives a length byte, 4N big-endian instruction bytes and an
// XOR checksum, writes each assembled word to instruction memory and holds the CPU until done.
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [7:0]            byteIn,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic                  imemWrite,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  output logic [31:0]           imemData,
  output logic                  cpuHold,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLen   = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StCheck = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StError = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] n_words;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic [1:0]            byte_cnt;
  logic [23:0]           word_sr;
  logic [7:0]            checksum;
  logic                  xfer;
  logic                  restart;
  logic                  last_byte;
  logic                  len_zero;

  // Transfer qualifier uses the registered ready, so no output depends on byteValid.
  assign xfer      = byteValid & byteReady;
  assign restart   = start & ((state_q == StIdle) | (state_q == StDone) | (state_q == StError));
  assign last_byte = (byte_cnt == 2'd3) && (word_cnt == n_words - ADDR_WIDTH'(1));
  assign len_zero  = (ADDR_WIDTH'(byteIn) == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StError: if (restart) state_d = StLen;
      StLen:   if (xfer) state_d = len_zero ? StCheck : StData;
      StData:  if (xfer && last_byte) state_d = StCheck;
      StCheck: if (xfer) state_d = (byteIn == checksum) ? StDone : StError;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= StIdle;
      n_words   <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      word_sr   <= '0;
      checksum  <= '0;
      byteReady <= 1'b0;
      imemWrite <= 1'b0;
      imemAddr  <= '0;
      imemData  <= '0;
      cpuHold   <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      byteReady <= (state_d == StLen) | (state_d == StData) | (state_d == StCheck);
      cpuHold   <= (state_d != StDone);
      done      <= (state_d == StDone);
      error     <= (state_d == StError);
      imemWrite <= 1'b0;

      if (restart) begin
        word_cnt <= '0;
        byte_cnt <= '0;
        checksum <= '0;
      end

      if (state_q == StLen && xfer) n_words <= ADDR_WIDTH'(byteIn);

      if (state_q == StData && xfer) begin
        checksum <= checksum ^ byteIn;
        byte_cnt <= byte_cnt + 2'd1;
        word_sr  <= {word_sr[15:0], byteIn};
        if (byte_cnt == 2'd3) begin
          imemWrite <= 1'b1;
          imemAddr  <= word_cnt;
          imemData  <= {word_sr, byteIn};
          word_cnt  <= word_cnt + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes are queued as bytes are driven and
// matched against imemWrite strobes by a monitor; status outputs are checked inline.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byteIn = 8'h00;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic        imemWrite;
  logic [7:0]  imemAddr;
  logic [31:0] imemData;
  logic        cpuHold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];

  program_loader #(.ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .start     (start),
    .byteIn    (byteIn),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .imemWrite (imemWrite),
    .imemAddr  (imemAddr),
    .imemData  (imemData),
    .cpuHold   (cpuHold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetN && imemWrite === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(imemAddr), 32'(e[39:32]));
        chk("write_data", imemData, e[31:0]);
      end
    end
  end

  // Entered and left at a falling edge; keeps byteValid high across back-to-back calls.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    byteValid = 1'b0;
    repeat (gap) @(negedge clk);
    byteIn = b;
    byteValid = 1'b1;
    t = 0;
    while (byteReady !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 32'(t), 32'd0);
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpuHold"}, 32'(cpuHold), 32'd1);
    chk({tag, "_byteReady"}, 32'(byteReady), 32'd0);
    chk({tag, "_imemWrite"}, 32'(imemWrite), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_imemAddr"}, 32'(imemAddr), 32'd0);
    chk({tag, "_imemData"}, imemData, 32'd0);
  endtask

  task automatic good_stream(input logic [7:0] last, input int max_gap);
    logic [7:0] s [10];
    s = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h00, 8'h00};
    s[9] = last;
    exp_q.push_back({8'h00, 32'h20010005});
    exp_q.push_back({8'h01, 32'h8C020000});
    for (int i = 0; i < 10; i++) send_byte(s[i], (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
    byteValid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    resetN = 1'b1;
    @(negedge clk);

    // Good load, contiguous stream
    pulse_start();
    chk("len_ready", 32'(byteReady), 32'd1);
    good_stream(8'hAA, 0);
    chk("good_done", 32'(done), 32'd1);
    chk("good_error", 32'(error), 32'd0);
    chk("good_cpuHold", 32'(cpuHold), 32'd0);
    chk("good_ready_low", 32'(byteReady), 32'd0);
    @(negedge clk);
    chk("good_writes_drained", 32'(exp_q.size()), 32'd0);

    // Restart from DONE raises cpuHold the next cycle, then a bad checksum
    pulse_start();
    chk("restart_cpuHold", 32'(cpuHold), 32'd1);
    chk("restart_done_clr", 32'(done), 32'd0);
    good_stream(8'hAB, 0);
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_cpuHold", 32'(cpuHold), 32'd1);
    @(negedge clk);
    chk("bad_writes_kept", 32'(exp_q.size()), 32'd0);

    // Empty load from ERROR
    pulse_start();
    chk("restart_error_clr", 32'(error), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_cpuHold", 32'(cpuHold), 32'd0);
    repeat (2) @(negedge clk);

    // Gapped stream after a byte offered in IDLE
    do_reset();
    byteIn = 8'h55;
    byteValid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready_low", 32'(byteReady), 32'd0);
    byteValid = 1'b0;
    pulse_start();
    good_stream(8'hAA, 3);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_error", 32'(error), 32'd0);
    @(negedge clk);
    chk("gap_writes_drained", 32'(exp_q.size()), 32'd0);

    // Reset after byte 6: word 0 written, partial word 1 discarded
    pulse_start();
    exp_q.push_back({8'h00, 32'h20010005});
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    send_byte(8'h8C, 0);
    do_reset();
    check_reset_vals("midreset");
    repeat (6) @(negedge clk);
    chk("midreset_no_write", 32'(exp_q.size()), 32'd0);
    chk("midreset_idle_ready", 32'(byteReady), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
